ex_mem_reg: RTL
===============

# ex_mem_reg

Pipeline register between the execute stage and the memory stage of the 16-bit pipelined processor. It captures one instruction's EX results and control each cycle and presents them to the memory stage. It holds its contents while data memory reports `Stall_DM`, and inserts bubbles on flush. After a valid HALT it freezes permanently, so the memory stage's dump request stays asserted. It also keeps a saturating count of data-memory stall cycles for performance inspection.

## Interface
- No parameters.
- `clk` — in, 1 — processor clock; all state updates on rising edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `ex_valid` — in, 1 — EX stage holds a real instruction.
- `ex_HALT`, `ex_MemWrite`, `ex_MemRead`, `ex_RegWrite`, `ex_MemToReg` — in, 1 each — control bits from EX.
- `ex_writeReg` — in, 3 — destination register index.
- `ex_ALUResult` — in, 16 — ALU result / data address.
- `ex_storeData` — in, 16 — store data.
- `flush` — in, 1 — squash the instruction currently offered by EX.
- `Stall_DM` — in, 1 — data-memory stall from the memory stage.
- `mem_valid` — out, 1 — register holds a real instruction.
- `HALT`, `MemWrite`, `MemRead`, `RegWrite`, `MemToReg` — out, 1 each — registered control, forced 0 when `mem_valid`=0.
- `writeReg` — out, 3 — registered destination index.
- `dataAddress` — out, 16 — registered ALU result.
- `writeData` — out, 16 — registered store data.
- `stall_upstream` — out, 1 — freeze IF/ID/EX; combinational, equals `Stall_DM | halted`.
- `halted` — out, 1 — HALTED state indicator.
- `stall_count` — out, 16 — saturating count of memory-stall cycles.

## Operation
- FSM has two states: RUN and HALTED. Reset enters RUN.
- **RUN, `Stall_DM`=1:**
  - All payload and valid hold; `flush` is ignored.
  - Upstream keeps `flush` asserted until the stall clears.
- **RUN, `Stall_DM`=0, `flush`=1:**
  - Load a bubble: `mem_valid`←0, all control bits←0.
  - Data fields are don't-care; the implementation loads 0.
- **RUN, `Stall_DM`=0, `flush`=0:**
  - Load all `ex_*` fields; `mem_valid`←`ex_valid`.
  - Control bits are stored ANDed with `ex_valid`.
- **RUN→HALTED:** on the edge where a valid, unflushed `ex_HALT`=1 is loaded.
- **HALTED:**
  - Register contents frozen regardless of `Stall_DM`, `flush` and `ex_*`.
  - `HALT` output stays 1.
  - Exit only via reset.
- **`stall_count`:**
  - Increments by 1 on each edge where state=RUN, `mem_valid`=1 and `Stall_DM`=1.
  - Saturates at 16'hFFFF and never wraps.
  - Not incremented in HALTED.
- **Simultaneous `ex_MemRead`=1 and `ex_MemWrite`=1:** stored as-is; read suppression is the memory stage's responsibility.

## Timing
- Latency is one cycle: EX values present on an edge appear on outputs immediately after that edge.
- **Reset (asynchronous, `rst_n`=0):**
  - `mem_valid`, all control outputs, `writeReg`, `dataAddress`, `writeData`, `stall_count` = 0.
  - State = RUN; `halted`=0.
  - `stall_upstream` = `Stall_DM`.
- Reset asserted mid-stall or in HALTED: outputs clear immediately, with no clock required.
- Reset deassertion: first load occurs on the first rising edge with `rst_n`=1.
- `stall_upstream` has zero latency, purely combinational from `Stall_DM` and state. EX must sample it in the same cycle.
- A stall lasting N cycles holds the register for exactly N edges. The instruction offered by EX loads on the first edge with `Stall_DM`=0.
- **Flush and HALT on the same offered instruction:** flush wins; it loads a bubble and stays in RUN.

## Test plan
- Reset then plain pipeline:
  - Stimulus: hold `rst_n`=0, then release; offer `ex_valid`=1, `ex_MemRead`=1, `ex_ALUResult`=16'h1234, `ex_writeReg`=3.
  - Required: next cycle `mem_valid`=1, `MemRead`=1, `dataAddress`=16'h1234, `writeReg`=3.
  - Required: all outputs 0 during reset.
- Three-cycle memory stall:
  - Stimulus: load a store to 16'h00A0 with data 16'hBEEF, then assert `Stall_DM` for 3 cycles while EX offers 16'h00A2.
  - Required: outputs hold 16'h00A0/16'hBEEF for 3 edges; `stall_upstream`=1 throughout; `stall_count`=3; 16'h00A2 loads on the 4th edge.
- Flush:
  - Stimulus: `flush`=1 with `ex_valid`=1, `ex_MemWrite`=1.
  - Required: next cycle `mem_valid`=0, `MemWrite`=0.
  - Stimulus: `flush`=1 during `Stall_DM`=1.
  - Required: held contents unchanged.
- HALT freeze:
  - Stimulus: load a valid `ex_HALT`=1, then offer further instructions and toggle `Stall_DM`.
  - Required: `HALT`=1, `halted`=1, `stall_upstream`=1 forever; `stall_count` constant; a bubble-wrapped HALT (`ex_valid`=0) does not halt.
- Counter saturation:
  - Stimulus: force `Stall_DM`=1 with a valid instruction for 65,540 cycles.
  - Required: `stall_count`=16'hFFFF, no wrap.
- Asynchronous reset mid-stall:
  - Stimulus: drop `rst_n` between clock edges while stalled with a valid instruction.
  - Required: `mem_valid`, `stall_count` and `halted` clear at once, without a clock edge.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: holds on data-memory stall, loads bubbles on flush,
// freezes after a valid HALT, and counts memory-stall cycles (saturating).
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_HALT,
  input  logic        ex_MemWrite,
  input  logic        ex_MemRead,
  input  logic        ex_RegWrite,
  input  logic        ex_MemToReg,
  input  logic [2:0]  ex_writeReg,
  input  logic [15:0] ex_ALUResult,
  input  logic [15:0] ex_storeData,
  input  logic        flush,
  input  logic        Stall_DM,
  output logic        mem_valid,
  output logic        HALT,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [2:0]  writeReg,
  output logic [15:0] dataAddress,
  output logic [15:0] writeData,
  output logic        stall_upstream,
  output logic        halted,
  output logic [15:0] stall_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        load_en, cnt_inc, take;
  logic        vld_p1;
  logic        halt_p1, mw_p1, mr_p1, rw_p1, m2r_p1;
  logic [2:0]  wreg_p1;
  logic [15:0] addr_p1, wdata_p1;
  logic [15:0] stall_cnt_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign take = ex_valid & ~flush;

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      RUN: begin
        load_en = ~Stall_DM;
        cnt_inc = Stall_DM & vld_p1;
        if (~Stall_DM && take && ex_HALT) state_d = HALTED;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // EX -> MEM boundary: a flushed slot loads all zeros; otherwise control is gated by ex_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      halt_p1  <= 1'b0;
      mw_p1    <= 1'b0;
      mr_p1    <= 1'b0;
      rw_p1    <= 1'b0;
      m2r_p1   <= 1'b0;
      wreg_p1  <= 3'd0;
      addr_p1  <= 16'd0;
      wdata_p1 <= 16'd0;
    end else if (load_en) begin
      if (flush) begin
        vld_p1   <= 1'b0;
        halt_p1  <= 1'b0;
        mw_p1    <= 1'b0;
        mr_p1    <= 1'b0;
        rw_p1    <= 1'b0;
        m2r_p1   <= 1'b0;
        wreg_p1  <= 3'd0;
        addr_p1  <= 16'd0;
        wdata_p1 <= 16'd0;
      end else begin
        vld_p1   <= ex_valid;
        halt_p1  <= ex_HALT & ex_valid;
        mw_p1    <= ex_MemWrite & ex_valid;
        mr_p1    <= ex_MemRead & ex_valid;
        rw_p1    <= ex_RegWrite & ex_valid;
        m2r_p1   <= ex_MemToReg & ex_valid;
        wreg_p1  <= ex_writeReg;
        addr_p1  <= ex_ALUResult;
        wdata_p1 <= ex_storeData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stall_cnt_p1 <= 16'd0;
    else if (cnt_inc) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign halted         = (state_q == HALTED);
  assign stall_upstream = Stall_DM | halted;
  assign mem_valid      = vld_p1;
  assign HALT           = halt_p1 & vld_p1;
  assign MemWrite       = mw_p1 & vld_p1;
  assign MemRead        = mr_p1 & vld_p1;
  assign RegWrite       = rw_p1 & vld_p1;
  assign MemToReg       = m2r_p1 & vld_p1;
  assign writeReg       = wreg_p1;
  assign dataAddress    = addr_p1;
  assign writeData      = wdata_p1;
  assign stall_count    = stall_cnt_p1;

endmodule
